// File: rtl/trig_sequencer.sv
// Shares one combinational cosine table across six lookups (cos/sin for X, Y, Z).
// A start request normalizes and latches the angles, steps through the table, then publishes all six results at once.
module trig_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] angle_x,
  input  logic [9:0] angle_y,
  input  logic [9:0] angle_z,
  output logic [9:0] lut_deg,
  input  logic [7:0] lut_val,
  output logic [7:0] cos_x,
  output logic [7:0] sin_x,
  output logic [7:0] cos_y,
  output logic [7:0] sin_y,
  output logic [7:0] cos_z,
  output logic [7:0] sin_z,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0] state;
  logic [2:0] step;
  logic [9:0] theta_x;
  logic [9:0] theta_y;
  logic [9:0] theta_z;
  logic [9:0] axis_theta;
  logic [7:0] shadow [0:5];

  // Fold 0..1023 into 0..359; at most two subtractions of 360 are ever needed.
  function automatic logic [9:0] norm_deg(input logic [9:0] a);
    if (a >= 10'd720) begin
      return a - 10'd720;
    end else if (a >= 10'd360) begin
      return a - 10'd360;
    end else begin
      return a;
    end
  endfunction

  // sin(t) = cos(t - 90), kept inside 0..359 without ever forming a value above 359.
  function automatic logic [9:0] sin_deg(input logic [9:0] t);
    if (t < 10'd90) begin
      return t + 10'd270;
    end else begin
      return t - 10'd90;
    end
  endfunction

  assign busy = (state == LOOKUP);
  assign done = (state == DONE);

  // Step mux: steps come in cos/sin pairs per axis, so step[2:1] picks the axis.
  always_comb begin
    axis_theta = 10'd0;
    lut_deg    = 10'd0;
    case (step[2:1])
      2'd0:    axis_theta = theta_x;
      2'd1:    axis_theta = theta_y;
      2'd2:    axis_theta = theta_z;
      default: axis_theta = 10'd0;
    endcase
    if (state == LOOKUP) begin
      lut_deg = step[0] ? sin_deg(axis_theta) : axis_theta;
    end else begin
      lut_deg = 10'd0;
    end
  end

  // Sequencer, shadow capture and coherent output publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      step    <= 3'd0;
      theta_x <= 10'd0;
      theta_y <= 10'd0;
      theta_z <= 10'd0;
      cos_x   <= 8'd0;
      sin_x   <= 8'd0;
      cos_y   <= 8'd0;
      sin_y   <= 8'd0;
      cos_z   <= 8'd0;
      sin_z   <= 8'd0;
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= 8'd0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            theta_x <= norm_deg(angle_x);
            theta_y <= norm_deg(angle_y);
            theta_z <= norm_deg(angle_z);
            step    <= 3'd0;
            state   <= LOOKUP;
          end else begin
            state   <= IDLE;
          end
        end
        LOOKUP: begin
          shadow[step] <= lut_val;
          if (step == 3'd5) begin
            // Last value bypasses its shadow so all six appear in the DONE cycle.
            cos_x <= shadow[0];
            sin_x <= shadow[1];
            cos_y <= shadow[2];
            sin_y <= shadow[3];
            cos_z <= shadow[4];
            sin_z <= lut_val;
            state <= DONE;
          end else begin
            step  <= step + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          step  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Scoreboard bench for trig_sequencer: a truncated-cosine table model drives lut_val,
// expected index sequences and result sets are queued at stimulus time and compared on output.
module tb_trig_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] angle_x, angle_y, angle_z;
  logic [9:0] lut_deg;
  logic [7:0] lut_val;
  logic [7:0] cos_x, sin_x, cos_y, sin_y, cos_z, sin_z;
  logic       busy, done;

  logic [7:0]  tab [0:1023];
  logic [47:0] exp_q [$];
  logic [9:0]  deg_q [$];
  logic [47:0] prev_outs;
  logic [47:0] outs;
  int          n_cmp = 0;
  int          n_bad = 0;
  string       names [6] = '{"cos_x", "sin_x", "cos_y", "sin_y", "cos_z", "sin_z"};

  trig_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z),
    .lut_deg(lut_deg), .lut_val(lut_val),
    .cos_x(cos_x), .sin_x(sin_x), .cos_y(cos_y), .sin_y(sin_y), .cos_z(cos_z), .sin_z(sin_z),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign lut_val = tab[lut_deg];
  assign outs    = {cos_x, sin_x, cos_y, sin_y, cos_z, sin_z};

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int nrm(input int a);
    if (a >= 720) return a - 720;
    else if (a >= 360) return a - 360;
    else return a;
  endfunction

  function automatic int sidx(input int t);
    return (t < 90) ? t + 270 : t - 90;
  endfunction

  function automatic logic [47:0] model_set(input int ax, input int ay, input int az);
    int tx = nrm(ax), ty = nrm(ay), tz = nrm(az);
    return {tab[tx], tab[sidx(tx)], tab[ty], tab[sidx(ty)], tab[tz], tab[sidx(tz)]};
  endfunction

  task automatic push_degs(input int ax, input int ay, input int az);
    int t [3];
    t[0] = nrm(ax); t[1] = nrm(ay); t[2] = nrm(az);
    for (int i = 0; i < 3; i++) begin
      deg_q.push_back(10'(t[i]));
      deg_q.push_back(10'(sidx(t[i])));
    end
  endtask

  // Output monitor: index sequence, result sets on done, and output stability between dones.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (busy) begin
        if (deg_q.size() == 0) check("busy_unexpected", int'(busy), 0);
        else check("lut_deg", int'(lut_deg), int'(deg_q.pop_front()));
      end else begin
        check("lut_deg_idle", int'(lut_deg), 0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          for (int i = 0; i < 6; i++) begin
            check(names[i], int'($signed(outs[47-8*i -: 8])), int'($signed(e[47-8*i -: 8])));
          end
        end
      end else begin
        check("coherence", int'(outs != prev_outs), 0);
      end
    end
    prev_outs = outs;
  end

  // One request; optionally pokes a second start (with other angles) while busy.
  task automatic run(input int ax, input int ay, input int az, input logic [47:0] expv, input bit poke);
    int k;
    @(negedge clk);
    angle_x = 10'(ax); angle_y = 10'(ay); angle_z = 10'(az);
    start = 1'b1;
    push_degs(ax, ay, az);
    exp_q.push_back(expv);
    for (k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) break;
      @(negedge clk);
      if (poke && k == 3) begin
        start = 1'b1;
        angle_x = 10'd123; angle_y = 10'd222; angle_z = 10'd333;
      end else begin
        start = 1'b0;
      end
    end
    check("latency", k, 7);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 1024; d++) begin
      tab[d] = 8'($rtoi(100.0 * $cos(real'(d) * 3.141592653589793 / 180.0)));
    end
    reset = 1'b1; start = 1'b0;
    angle_x = 10'd0; angle_y = 10'd0; angle_z = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_lut_deg", int'(lut_deg), 0);
    check("rst_outs_nonzero", int'(outs != 48'd0), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic lookup and wrap/sine-shift, expectations taken from hand-computed values
    run(0, 90, 180, {8'd100, 8'd0, 8'd0, 8'd100, 8'h9C, 8'd0}, 1'b0);
    run(400, 1023, 45, {8'd76, 8'd64, 8'd54, 8'hAD, 8'd70, 8'd70}, 1'b0);

    // Start while busy: ignored, results from first angles, single done
    run(10, 200, 359, model_set(10, 200, 359), 1'b1);
    repeat (10) @(negedge clk);

    // Boundary angles and a few random ones
    run(360, 719, 720, model_set(360, 719, 720), 1'b0);
    run(89, 90, 1023, model_set(89, 90, 1023), 1'b0);
    for (int r = 0; r < 3; r++) begin
      int ax, ay, az;
      ax = int'($urandom_range(0, 1023));
      ay = int'($urandom_range(0, 1023));
      az = int'($urandom_range(0, 1023));
      run(ax, ay, az, model_set(ax, ay, az), 1'b0);
    end

    // Back-to-back: start held 20 cycles, angles changed between runs
    @(negedge clk);
    angle_x = 10'd30; angle_y = 10'd60; angle_z = 10'd120;
    push_degs(30, 60, 120);   exp_q.push_back(model_set(30, 60, 120));
    push_degs(500, 850, 7);   exp_q.push_back(model_set(500, 850, 7));
    push_degs(270, 1000, 91); exp_q.push_back(model_set(270, 1000, 91));
    start = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_done_%0d", k), int'(done), int'(k == 6 || k == 13 || k == 20));
      check($sformatf("b2b_busy_%0d", k), int'(busy), int'(k < 20 && k != 6 && k != 13));
      @(negedge clk);
      if (k == 0) begin
        angle_x = 10'd500; angle_y = 10'd850; angle_z = 10'd7;
      end else if (k == 7) begin
        angle_x = 10'd270; angle_y = 10'd1000; angle_z = 10'd91;
      end
      if (k == 19) start = 1'b0;
    end

    // Reset during step 3
    @(negedge clk);
    angle_x = 10'd100; angle_y = 10'd200; angle_z = 10'd300;
    start = 1'b1;
    push_degs(100, 200, 300);
    exp_q.push_back(model_set(100, 200, 300));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    deg_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_lut_deg", int'(lut_deg), 0);
    check("abort_outs_nonzero", int'(outs != 48'd0), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    run(45, 135, 225, model_set(45, 135, 225), 1'b0);
    repeat (5) @(negedge clk);

    check("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trig_sequencer.md
# trig_sequencer

Time-multiplexes one shared combinational cosine lookup port to produce cosine and sine for the X, Y and Z rotation angles of the cube renderer. A single start request is expanded into six sequential lookups, with angle wrap and the sine→cosine index shift done in-block. All six results are presented together with a one-cycle done pulse. The block sits between the angle accumulator and the rotation-matrix multiplier and removes the need for three parallel 361-entry tables.

## Interface
- Parameters: none. The table range is fixed: degrees 0..360, values are signed 8-bit scaled by 100.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- angle_x, angle_y, angle_z  in  10 each  unsigned degrees, 0..1023 accepted.
- lut_deg  out  10  index driven to the shared cosine table, always 0..359.
- lut_val  in  8  signed cosine of lut_deg, combinational, valid in the same cycle.
- cos_x, sin_x, cos_y, sin_y, cos_z, sin_z  out  8 each  signed results ×100.
- busy  out  1  high while lookups are in progress.
- done  out  1  one-cycle pulse when a new result set is on the outputs.

## Operation
- **FSM states:** IDLE → LOOKUP → DONE → IDLE.
  - DONE → LOOKUP directly if start = 1 in DONE.
- **On accepted start:** latch all three angles after normalization and clear the step counter (3-bit).
  - Normalization: a ≥ 720 → a−720; else a ≥ 360 → a−360; else a. Result is 0..359.
- **LOOKUP:** step k = 0..5 selects a table index. Let θ be the normalized angle for the axis.
  - Order: cos X, sin X, cos Y, sin Y, cos Z, sin Z.
  - cos index = θ.
  - sin index = θ+270 if θ < 90, else θ−90.
  - lut_val is captured into a shadow register for step k at the end of that cycle.
  - After step 5, go to DONE.
- **DONE:**
  - All six outputs load simultaneously from the shadow registers, so outputs never show a mixed set.
  - done = 1 for exactly this cycle.
- **Output hold:** outputs hold their value until the next DONE.
- **lut_deg:** driven from the step mux in LOOKUP; 0 in IDLE and DONE.
- **start while busy:** ignored, with no queueing. Angle inputs are not observed after latching.
- **Reset:** takes effect in any state and at any step.
  - State → IDLE, counter → 0.
  - busy, done, lut_deg and all six results → 0.
  - Shadow registers → 0.
  - An aborted sequence never asserts done.
- **Arithmetic:** all index math is unsigned 10-bit with no overflow (max 359+270 is never formed, since +270 applies only for θ < 90). Results pass through unmodified as 8-bit two's complement.

## Timing
- Cycle 0: start = 1 sampled in IDLE.
- Cycles 1–6: LOOKUP steps 0–5, busy = 1, lut_deg valid for the whole cycle.
- Cycle 7: DONE, done = 1, busy = 0, new outputs visible.
- Latency from start to done is 7 cycles.
- Throughput is one set per 7 cycles when start is held high, because start is re-accepted in DONE.
- The shared table must settle within one clk period (combinational path lut_deg → lut_val → shadow register).
- Reset state: busy = 0, done = 0, lut_deg = 0, all outputs 0, state IDLE.

## Test plan
- **Basic lookup:** angles (0, 90, 180) → lut_deg sequence 0, 270, 90, 0, 180, 90.
  - Outputs: cos_x = 100, sin_x = 0, cos_y = 0, sin_y = 100, cos_z = −100 (8'h9C), sin_z = 0.
  - done at cycle 7.
- **Wrap and sine shift:** angles (400, 1023, 45) normalize to (40, 303, 45).
  - Outputs: cos_x = 76, sin_x = 64 (idx 310), cos_y = 54, sin_y = −83 (idx 213), cos_z = 70, sin_z = 70 (idx 315).
- **Start while busy:** pulse start at cycle 3 with different angles → ignored.
  - done only at cycle 7, results from the first angles.
  - Exactly one done pulse.
- **Back-to-back:** start held high for 20 cycles → done pulses at cycles 7, 14 and 21.
  - busy low only in DONE cycles.
  - Angles changed between runs are reflected in the following result set.
- **Reset mid-operation:** assert reset at step 3.
  - Next cycle: all outputs 0, busy = 0, lut_deg = 0.
  - No done pulse.
  - A fresh start completes normally 7 cycles later.
- **Output coherence:** monitor the six outputs every cycle → they change only in cycles where done = 1.
